// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode and arbiter state encodings, plus the settle-count helper.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_FORWARD = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_AND     = 3'b010;
  localparam logic [2:0] OP_OR      = 3'b011;
  localparam logic [2:0] OP_MULT    = 3'b100;
  localparam logic [2:0] OP_SL      = 3'b101;
  localparam logic [2:0] OP_SRA     = 3'b110;
  localparam logic [2:0] OP_ROR     = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter preload is W-1; a zero wait is promoted to one, and W saturates at the 4-bit range.
  function automatic logic [3:0] wait_load(input logic [2:0] op, input int unsigned basic,
                                           input int unsigned mult, input int unsigned shift);
    int unsigned w;
    if (op <= OP_OR) begin
      w = basic;
    end else if (op == OP_MULT) begin
      w = mult;
    end else begin
      w = shift;
    end
    if (w == 0) w = 1;
    if (w > 15) w = 15;
    return 4'(w - 1);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins.
module rr_arb2
  import alu_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_served,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req0 && req1) begin
      grant = last_served ? 2'b01 : 2'b10;
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: arbitrate, register operands, wait for
// the opcode-dependent settle time, capture the result and pulse DONE to the winner.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned BASIC_WAIT = 1,
  parameter int unsigned MULT_WAIT  = 2,
  parameter int unsigned SHIFT_WAIT = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic [2:0] OP0,
  input  logic [7:0] A0,
  input  logic [7:0] B0,
  input  logic       REQ1,
  input  logic [2:0] OP1,
  input  logic [7:0] A1,
  input  logic [7:0] B1,
  output logic       DONE0,
  output logic       DONE1,
  output logic [7:0] RESULT_OUT,
  output logic       ZERO_OUT,
  output logic       BUSY,
  output logic [7:0] ALU_DATA1,
  output logic [7:0] ALU_DATA2,
  output logic [2:0] ALU_SELECT,
  input  logic [7:0] ALU_RESULT,
  input  logic       ALU_ZERO
);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       served;
  logic       last_served;
  logic [1:0] grant;
  logic [2:0] op_sel;

  rr_arb2 u_rr_arb2 (
    .req0        (REQ0),
    .req1        (REQ1),
    .last_served (last_served),
    .grant       (grant)
  );

  assign op_sel = grant[1] ? OP1 : OP0;
  assign BUSY   = (state != S_IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      served      <= 1'b0;
      last_served <= 1'b1; // requester 0 wins the first tie
      ALU_DATA1   <= 8'd0;
      ALU_DATA2   <= 8'd0;
      ALU_SELECT  <= OP_FORWARD;
      RESULT_OUT  <= 8'd0;
      ZERO_OUT    <= 1'b0;
      DONE0       <= 1'b0;
      DONE1       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant != 2'b00) begin
            served     <= grant[1];
            ALU_DATA1  <= grant[1] ? A1 : A0;
            ALU_DATA2  <= grant[1] ? B1 : B0;
            ALU_SELECT <= op_sel;
            cnt        <= wait_load(op_sel, BASIC_WAIT, MULT_WAIT, SHIFT_WAIT);
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            RESULT_OUT <= ALU_RESULT;
            ZERO_OUT   <= ALU_ZERO;
            DONE0      <= ~served;
            DONE1      <= served;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          DONE0       <= 1'b0;
          DONE1       <= 1'b0;
          last_served <= served;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in ALU, a transaction-timestamp model compared
// every cycle, and directed scenarios with hand-computed expectations.
module tb_alu_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ0 = 1'b0, REQ1 = 1'b0;
  logic [2:0] OP0 = 3'd0, OP1 = 3'd0;
  logic [7:0] A0 = 8'd0, B0 = 8'd0, A1 = 8'd0, B1 = 8'd0;
  logic       DONE0, DONE1, ZERO_OUT, BUSY, ALU_ZERO;
  logic [7:0] RESULT_OUT, ALU_DATA1, ALU_DATA2, ALU_RESULT;
  logic [2:0] ALU_SELECT;

  int errors = 0;
  int checks = 0;
  bit sim_over = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(
    .BASIC_WAIT (1),
    .MULT_WAIT  (2),
    .SHIFT_WAIT (2)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .REQ0       (REQ0),
    .OP0        (OP0),
    .A0         (A0),
    .B0         (B0),
    .REQ1       (REQ1),
    .OP1        (OP1),
    .A1         (A1),
    .B1         (B1),
    .DONE0      (DONE0),
    .DONE1      (DONE1),
    .RESULT_OUT (RESULT_OUT),
    .ZERO_OUT   (ZERO_OUT),
    .BUSY       (BUSY),
    .ALU_DATA1  (ALU_DATA1),
    .ALU_DATA2  (ALU_DATA2),
    .ALU_SELECT (ALU_SELECT),
    .ALU_RESULT (ALU_RESULT),
    .ALU_ZERO   (ALU_ZERO)
  );

  function automatic logic [7:0] alu_fn(input logic [2:0] sel, input logic [7:0] d1,
                                        input logic [7:0] d2);
    logic [15:0] prod;
    logic [15:0] dbl;
    prod = {8'd0, d1} * {8'd0, d2};
    dbl  = {d1, d1} >> d2[2:0];
    case (sel)
      3'b000:  return d2;
      3'b001:  return d1 + d2;
      3'b010:  return d1 & d2;
      3'b011:  return d1 | d2;
      3'b100:  return prod[7:0];
      3'b101:  return d1 << d2[2:0];
      3'b110:  return $signed(d1) >>> d2[2:0];
      default: return dbl[7:0];
    endcase
  endfunction

  function automatic int class_wait(input logic [2:0] op);
    if (op <= 3'b011) return 1;
    if (op == 3'b100) return 2;
    return 2;
  endfunction

  assign ALU_RESULT = alu_fn(ALU_SELECT, ALU_DATA1, ALU_DATA2);
  assign ALU_ZERO   = (ALU_RESULT == 8'd0);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Model: an accepted operation finishes W edges later and frees the block two edges after that.
  int         cyc, free_at, done_edge, who_m, last_m;
  bit         pending;
  logic [7:0] e_res, e_d1, e_d2, p_res;
  logic [2:0] e_sel;
  logic       e_zero, p_zero, e_done0, e_done1, e_busy;

  task automatic model_clear();
    free_at = 0; pending = 0; last_m = 1; who_m = 0;
    e_res = 0; e_zero = 0; e_d1 = 0; e_d2 = 0; e_sel = 0;
    e_done0 = 0; e_done1 = 0; e_busy = 0;
  endtask

  initial begin
    cyc = 0;
    model_clear();
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) begin
        model_clear();
      end else begin
        e_done0 = 0;
        e_done1 = 0;
        if (pending && cyc == done_edge) begin
          e_res  = p_res;
          e_zero = p_zero;
          if (who_m == 0) e_done0 = 1; else e_done1 = 1;
          pending = 0;
        end
        if (cyc >= free_at && (REQ0 || REQ1)) begin
          if (REQ0 && REQ1) who_m = 1 - last_m;
          else who_m = REQ0 ? 0 : 1;
          last_m    = who_m;
          e_d1      = (who_m == 1) ? A1 : A0;
          e_d2      = (who_m == 1) ? B1 : B0;
          e_sel     = (who_m == 1) ? OP1 : OP0;
          p_res     = alu_fn(e_sel, e_d1, e_d2);
          p_zero    = (p_res == 8'd0);
          done_edge = cyc + class_wait(e_sel);
          free_at   = done_edge + 2;
          pending   = 1;
        end
        e_busy = (cyc < free_at - 1);
        cyc++;
      end
    end
  end

  initial begin
    @(negedge CLK);
    while (!sim_over) begin
      check("done0", DONE0, e_done0);
      check("done1", DONE1, e_done1);
      check("busy", BUSY, e_busy);
      check("result_out", RESULT_OUT, e_res);
      check("zero_out", ZERO_OUT, e_zero);
      check("alu_data1", ALU_DATA1, e_d1);
      check("alu_data2", ALU_DATA2, e_d2);
      check("alu_select", ALU_SELECT, e_sel);
      @(negedge CLK);
    end
  end

  // Returns at the negedge where a DONE is seen; lat counts negedges waited.
  task automatic wait_done(output int who, output int lat);
    who = -1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      lat++;
      if (DONE0 || DONE1) begin
        who = DONE1 ? 1 : 0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no DONE expected a DONE within 20 cycles at %0t", $time);
  endtask

  int  who, lat;
  time t_done [4];

  initial begin
    repeat (2) @(negedge CLK);
    check("reset_busy", BUSY, 0);
    check("reset_select", ALU_SELECT, 0);
    check("reset_done0", DONE0, 0);
    RESET = 1'b0;
    @(negedge CLK);

    // 1: ADD 5+3 from requester 0
    REQ0 = 1; OP0 = 3'b001; A0 = 8'd5; B0 = 8'd3;
    wait_done(who, lat);
    check("t1_who", who, 0);
    check("t1_latency", lat, 2);
    check("t1_result", RESULT_OUT, 8);
    check("t1_zero", ZERO_OUT, 0);
    check("t1_done1", DONE1, 0);
    REQ0 = 0;
    @(negedge CLK);
    check("t1_idle_after", BUSY, 0);

    // 2: MULT 3*4 from requester 1
    @(negedge CLK);
    REQ1 = 1; OP1 = 3'b100; A1 = 8'd3; B1 = 8'd4;
    wait_done(who, lat);
    check("t2_who", who, 1);
    check("t2_latency", lat, 3);
    check("t2_result", RESULT_OUT, 12);
    check("t2_busy_in_done", BUSY, 1);
    REQ1 = 0;
    @(negedge CLK);

    // 3: simultaneous, held requests alternate
    REQ0 = 1; OP0 = 3'b001; A0 = 8'd5; B0 = 8'hFB;
    REQ1 = 1; OP1 = 3'b011; A1 = 8'h0F; B1 = 8'hF0;
    wait_done(who, lat);
    check("t3_first_who", who, 0);
    check("t3_first_result", RESULT_OUT, 0);
    check("t3_first_zero", ZERO_OUT, 1);
    wait_done(who, lat);
    check("t3_second_who", who, 1);
    check("t3_second_result", RESULT_OUT, 8'hFF);
    check("t3_second_zero", ZERO_OUT, 0);
    wait_done(who, lat);
    check("t3_third_who", who, 0);
    wait_done(who, lat);
    check("t3_fourth_who", who, 1);
    REQ0 = 0; REQ1 = 0;
    @(negedge CLK);

    // 4: operand change after acceptance is ignored
    REQ0 = 1; OP0 = 3'b001; A0 = 8'd1; B0 = 8'd1;
    @(negedge CLK);
    A0 = 8'd100;
    wait_done(who, lat);
    check("t4_result", RESULT_OUT, 2);
    REQ0 = 0;
    @(negedge CLK);

    // 5: reset while a MULT is pending
    REQ0 = 1; OP0 = 3'b100; A0 = 8'd7; B0 = 8'd9;
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("t5_busy", BUSY, 0);
    check("t5_done0", DONE0, 0);
    check("t5_result", RESULT_OUT, 0);
    check("t5_data1", ALU_DATA1, 0);
    check("t5_data2", ALU_DATA2, 0);
    REQ0 = 0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    REQ0 = 1; OP0 = 3'b000; A0 = 8'd0; B0 = 8'h5A;
    REQ1 = 1; OP1 = 3'b001; A1 = 8'd1; B1 = 8'd2;
    wait_done(who, lat);
    check("t5_tie_who", who, 0);
    check("t5_tie_result", RESULT_OUT, 8'h5A);
    REQ0 = 0; REQ1 = 0;
    @(negedge CLK);

    // 6: single held request, one operation every W+2 cycles
    REQ0 = 1; OP0 = 3'b010; A0 = 8'hFF; B0 = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      wait_done(who, lat);
      t_done[k] = $time;
    end
    check("t6_result", RESULT_OUT, 8'h3C);
    for (int k = 1; k < 4; k++) begin
      check("t6_period", int'(t_done[k] - t_done[k-1]), 30);
    end
    REQ0 = 0;
    repeat (3) @(negedge CLK);

    sim_over = 1;
    @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
